// File: rtl/controlador_de_ataque.sv
// Attack manager for the battleship board: checks each confirmed shot against the
// hidden ship map and tracks hits, shot history, lives and the end of the game.
//
// state   | meaning
// OCIOSO  | just cleared, arms on the next enabled edge
// AGUARDA | waiting for a confirm edge, latches coordinates
// AVALIA  | single-cycle evaluation of the latched shot
// FIM     | game over, confirm pulses ignored until clear
module controlador_de_ataque #(
    parameter int LINHAS        = 7,
    parameter int COLUNAS       = 5,
    parameter int LARGURA_COORD = 3,
    parameter int VIDAS         = 3,
    parameter int LARGURA_VIDA  = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      confirmar,
    input  logic [LARGURA_COORD-1:0]  coordColuna,
    input  logic [LARGURA_COORD-1:0]  coordLinha,
    input  logic [LINHAS*COLUNAS-1:0] mapa,
    output logic [LINHAS*COLUNAS-1:0] matriz,
    output logic [LINHAS*COLUNAS-1:0] tiros,
    output logic                      LED_R,
    output logic                      LED_G,
    output logic                      LED_B,
    output logic [LARGURA_VIDA-1:0]   vida,
    output logic                      fim_de_jogo,
    output logic                      vitoria
);

    localparam int N           = LINHAS * COLUNAS;
    localparam int LARGURA_IDX = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {OCIOSO, AGUARDA, AVALIA, FIM} estado_t;

    estado_t                  estado, estado_n;
    logic                     confirmar_q;
    logic                     pulso;
    logic [LARGURA_COORD-1:0] col_q, col_n;
    logic [LARGURA_COORD-1:0] lin_q, lin_n;
    logic [N-1:0]             matriz_n, tiros_n;
    logic                     led_r_n, led_g_n, led_b_n;
    logic [LARGURA_VIDA-1:0]  vida_n;
    logic                     fim_n, vitoria_n;
    logic                     valido;
    logic [LARGURA_IDX-1:0]   idx;

    assign pulso  = confirmar & ~confirmar_q;
    assign valido = (int'(col_q) < COLUNAS) && (int'(lin_q) < LINHAS);
    // Index only meaningful when valido; computed in 32 bits so the top cell never wraps.
    assign idx    = LARGURA_IDX'(int'(col_q) * LINHAS + int'(lin_q));

    always_ff @(posedge clock) begin
        if (!reset || !enable) begin
            estado      <= OCIOSO;
            confirmar_q <= 1'b0;
            col_q       <= '0;
            lin_q       <= '0;
            matriz      <= '0;
            tiros       <= '0;
            LED_R       <= 1'b0;
            LED_G       <= 1'b0;
            LED_B       <= 1'b0;
            vida        <= LARGURA_VIDA'(VIDAS);
            fim_de_jogo <= 1'b0;
            vitoria     <= 1'b0;
        end else begin
            estado      <= estado_n;
            confirmar_q <= confirmar;
            col_q       <= col_n;
            lin_q       <= lin_n;
            matriz      <= matriz_n;
            tiros       <= tiros_n;
            LED_R       <= led_r_n;
            LED_G       <= led_g_n;
            LED_B       <= led_b_n;
            vida        <= vida_n;
            fim_de_jogo <= fim_n;
            vitoria     <= vitoria_n;
        end
    end

    always_comb begin
        estado_n  = estado;
        col_n     = col_q;
        lin_n     = lin_q;
        matriz_n  = matriz;
        tiros_n   = tiros;
        led_r_n   = LED_R;
        led_g_n   = LED_G;
        led_b_n   = LED_B;
        vida_n    = vida;
        fim_n     = fim_de_jogo;
        vitoria_n = vitoria;

        case (estado)
            OCIOSO: estado_n = AGUARDA;

            AGUARDA: begin
                if (pulso) begin
                    col_n    = coordColuna;
                    lin_n    = coordLinha;
                    estado_n = AVALIA;
                end
            end

            AVALIA: begin
                if (!valido || tiros[idx]) begin
                    led_r_n = 1'b0;
                    led_g_n = 1'b0;
                    led_b_n = 1'b1;
                end else if (mapa[idx]) begin
                    matriz_n[idx] = 1'b1;
                    tiros_n[idx]  = 1'b1;
                    led_r_n       = 1'b0;
                    led_g_n       = 1'b1;
                    led_b_n       = 1'b0;
                end else begin
                    tiros_n[idx] = 1'b1;
                    led_r_n      = 1'b1;
                    led_g_n      = 1'b0;
                    led_b_n      = 1'b0;
                    if (vida != '0)
                        vida_n = vida - LARGURA_VIDA'(1);
                end

                // End-of-game is judged on the post-update values, victory first.
                if (((matriz_n & mapa) == mapa) && (mapa != '0)) begin
                    vitoria_n = 1'b1;
                    fim_n     = 1'b1;
                    estado_n  = FIM;
                end else if (vida_n == '0) begin
                    fim_n    = 1'b1;
                    estado_n = FIM;
                end else begin
                    estado_n = AGUARDA;
                end
            end

            FIM: fim_n = 1'b1;

            default: estado_n = OCIOSO;
        endcase
    end

endmodule

// File: doc/controlador_de_ataque.md
Name: controlador_de_ataque

Overview:
- Parametrised, fully synchronous successor of the attack manager for the battleship game.
- Takes shot coordinates and a confirm button, and checks each shot against the hidden ship map.
- Keeps a hit matrix for the LED display, a separate shot-history matrix and a life counter.
- Detects repeated or out-of-range shots, and declares victory or defeat through a small FSM.
- Sits between the input/debounce logic and the LED matrix scanner.

Parameters:
- LINHAS, 7, rows per column of the board.
- COLUNAS, 5, number of columns.
- LARGURA_COORD, 3, width of each coordinate input.
- VIDAS, 3, initial life count.
- LARGURA_VIDA, 3, width of vida; must hold VIDAS.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous reset, active-low.
- enable  in  1  game-active; low behaves as a synchronous clear.
- confirmar  in  1  confirm button, already debounced and synchronous, level input.
- coordColuna  in  LARGURA_COORD  target column.
- coordLinha  in  LARGURA_COORD  target row.
- mapa  in  LINHAS*COLUNAS  ship map; bit index = coluna*LINHAS + linha.
- matriz  out  LINHAS*COLUNAS  hit cells, same indexing.
- tiros  out  LINHAS*COLUNAS  every cell already fired at.
- LED_R  out  1  last shot missed.
- LED_G  out  1  last shot hit.
- LED_B  out  1  last shot repeated or out of range.
- vida  out  LARGURA_VIDA  remaining lives.
- fim_de_jogo  out  1  game over.
- vitoria  out  1  game over with a win.

Behaviour:
- Reset (reset=0 at an edge) and enable=0 have identical effect:
  - matriz=0, tiros=0.
  - LED_R=LED_G=LED_B=0.
  - vida=VIDAS.
  - fim_de_jogo=0, vitoria=0.
  - state=OCIOSO, confirm edge register cleared.
  - reset has priority over enable.
- Confirm edge detection: pulso = confirmar & ~confirmar_q, with confirmar_q registered each cycle. Holding confirmar high yields exactly one shot.
- FSM OCIOSO: moves to AGUARDA on the first edge with enable=1.
- FSM AGUARDA: on pulso=1, latch both coordinates and go to AVALIA. Otherwise stay.
- FSM AVALIA (single cycle): evaluate the latched shot, update outputs, then go to FIM if the game ended, else AGUARDA.
  - Invalid (coordColuna>=COLUNAS or coordLinha>=LINHAS) or cell already in tiros: LED_B=1, R=G=0. No other change.
  - Hit (mapa bit = 1): set the matriz and tiros bits, LED_G=1, R=B=0.
  - Miss: set the tiros bit, LED_R=1, G=B=0, vida decremented by 1 (saturates at 0).
- FSM FIM: fim_de_jogo=1. All confirm pulses are ignored; outputs hold until enable=0 or reset.
- Game-end conditions, checked on post-update values:
  - Victory: (matriz & mapa) == mapa and mapa != 0. Sets vitoria=1 and goes to FIM.
  - Defeat: vida == 0. Goes to FIM with vitoria=0.
  - Victory is tested first. A hit can never zero vida, so both cannot be true together.
- Latency: confirmar is sampled high at edge N (low at N-1), so AVALIA is entered at N. Results (LEDs, matriz, vida, flags) are visible after edge N+1.
- A pulso arriving while in AVALIA is dropped. The button needs at least one low cycle between shots.
- LEDs are one-hot after any evaluation and hold until the next evaluation or a clear.
- mapa is sampled only in AVALIA and must be stable while enable=1.
- A shot on the highest legal cell (COLUNAS-1, LINHAS-1) must index bit LINHAS*COLUNAS-1 with no wrap.

Test Plan:
- Defaults; mapa column0=7'b1110001, column1=7'b0100000, column4=7'b1110000, rest 0. Pulse at (col0,row0) -> after 2 cycles matriz[0]=1, tiros[0]=1, LED_G=1, vida=3.
- Shot (col1,row5), then a second shot at (col1,row5) -> first: LED_G=1, matriz[12]=1. Second: LED_B=1, vida unchanged at 3, matriz unchanged.
- Misses at (2,0), (2,1), (2,2) -> vida 2, 1, 0, LED_R=1 each time. After the third: fim_de_jogo=1, vitoria=0. A further pulse at (0,4) changes nothing.
- Hit all 8 ship cells in any order -> after the last evaluation vitoria=1 and fim_de_jogo=1. matriz equals mapa.
- Out-of-range shot (col5,row0) and (col0,row7) -> LED_B=1, tiros=0, vida=3. Holding confirmar high for 10 cycles yields exactly one evaluation.
- Mid-game: drop enable for one cycle -> everything returns to reset values with vida=3. Then assert reset=0 in the same cycle as a confirm edge -> no shot is recorded.
